// File: rtl/pcie_ss_axis_pkt_fifo.sv
// Packet-aware AXI-S FIFO feeding a PCIe SS source port: RAM plus registered output stage.
// Optional store-and-forward mode is enabled by defining PCIE_SS_AXIS_PKT_FIFO_SAF_EN.
module pcie_ss_axis_pkt_fifo #(
  parameter int DATA_W   = 512,
  parameter int USER_W   = 10,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_tvalid_i,
  input  logic                   s_tlast_i,
  input  logic [USER_W-1:0]      s_tuser_vendor_i,
  input  logic [DATA_W-1:0]      s_tdata_i,
  input  logic [DATA_W/8-1:0]    s_tkeep_i,
  output logic                   s_tready_o,
  output logic                   m_tvalid_o,
  output logic                   m_tlast_o,
  output logic [USER_W-1:0]      m_tuser_vendor_o,
  output logic [DATA_W-1:0]      m_tdata_o,
  output logic [DATA_W/8-1:0]    m_tkeep_o,
  input  logic                   m_tready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [$clog2(DEPTH):0] pkt_cnt_o,
  output logic                   almost_full_o,
  output logic                   saf_ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = DATA_W / 8;
  localparam int WW = DATA_W + KW + USER_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] s_word;
  logic [WW-1:0] out_q;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          s_tready_q;
  logic          m_tvalid_q, m_tvalid_d;
  logic          almost_full_q;
  logic          push, pop, load, rel_ok;

  assign s_word = {s_tlast_i, s_tuser_vendor_i, s_tkeep_i, s_tdata_i};

  // count covers RAM plus the output register; ram_cnt covers only beats not yet moved out.
  always_comb begin
    push       = s_tvalid_i & s_tready_q;
    pop        = m_tvalid_q & m_tready_i;
    load       = (ram_cnt_q != '0) & (~m_tvalid_q | m_tready_i) & rel_ok;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(load);
    ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(load);
    count_d    = count_q + CW'(push) - CW'(pop);
    pkt_cnt_d  = pkt_cnt_q + CW'(push & s_tlast_i) - CW'(pop & out_q[WW-1]);
    m_tvalid_d = load | (m_tvalid_q & ~m_tready_i);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= s_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ram_cnt_q     <= '0;
      pkt_cnt_q     <= '0;
      s_tready_q    <= 1'b0;
      m_tvalid_q    <= 1'b0;
      almost_full_q <= 1'b0;
      out_q         <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ram_cnt_q     <= ram_cnt_d;
      pkt_cnt_q     <= pkt_cnt_d;
      s_tready_q    <= (count_d < DEPTH_C);
      m_tvalid_q    <= m_tvalid_d;
      almost_full_q <= (count_d >= AFULL_C);
      if (load) begin
        out_q <= mem[rd_ptr_q];
      end
    end
  end

`ifdef PCIE_SS_AXIS_PKT_FIFO_SAF_EN
  logic          last_mem [DEPTH];
  logic          mid_q, cut_q, ovf_q;
  logic [CW-1:0] ram_pkts;

  always_ff @(posedge clk) begin
    if (push) begin
      last_mem[wr_ptr_q] <= s_tlast_i;
    end
  end

  // Complete packets still in RAM: exclude a tlast beat sitting in the output register.
  assign ram_pkts = pkt_cnt_q - CW'(m_tvalid_q & out_q[WW-1]);
  assign rel_ok   = mid_q | cut_q | (ram_pkts != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mid_q <= 1'b0;
      cut_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (load) begin
        mid_q <= ~last_mem[rd_ptr_q];
        if (last_mem[rd_ptr_q]) begin
          cut_q <= 1'b0;
        end
      end
      // Full with no complete packet can never drain in SAF; fall back to cut-through.
      if ((count_q == DEPTH_C) && (pkt_cnt_q == '0)) begin
        cut_q <= 1'b1;
        ovf_q <= 1'b1;
      end
    end
  end

  assign saf_ovf_o = ovf_q;
`else
  assign rel_ok    = 1'b1;
  assign saf_ovf_o = 1'b0;
`endif

  assign s_tready_o       = s_tready_q;
  assign m_tvalid_o       = m_tvalid_q;
  assign m_tlast_o        = out_q[WW-1];
  assign m_tuser_vendor_o = out_q[WW-2 -: USER_W];
  assign m_tkeep_o        = out_q[DATA_W +: KW];
  assign m_tdata_o        = out_q[DATA_W-1:0];
  assign count_o          = count_q;
  assign pkt_cnt_o        = pkt_cnt_q;
  assign almost_full_o    = almost_full_q;

endmodule

// File: doc/pcie_ss_axis_pkt_fifo.md
Name: pcie_ss_axis_pkt_fifo

Overview:
Packet-aware AXI-S FIFO that sits directly upstream of a PCIe SS AXI-S interface source modport, e.g. between AFU TX logic and the PCIe SS TX port. It buffers TLP beats (tdata/tkeep/tlast/tuser_vendor) across a fixed-depth RAM. It presents a registered, protocol-clean source: tvalid is held until tready, and no X appears on payload while tvalid is high. It also exports occupancy and stored-packet status for upstream flow control.

Parameters:
DATA_W, pcie_ss_pkg::TDATA_WIDTH, tdata width in bits; multiple of 8
USER_W, pcie_ss_pkg::TUSER_WIDTH, tuser_vendor width in bits
DEPTH, 16, total beat capacity including output register; power of two, >=4
AFULL_TH, DEPTH-4, almost_full asserts when count >= AFULL_TH; range 1..DEPTH

Ports:
clk  in  1  clock; all logic single-domain
rst_n  in  1  synchronous active-low reset
s_tvalid  in  1  sink beat valid
s_tlast  in  1  sink end of packet
s_tuser_vendor  in  USER_W  sink sideband
s_tdata  in  DATA_W  sink payload
s_tkeep  in  DATA_W/8  sink byte enables
s_tready  out  1  sink ready; registered
m_tvalid  out  1  source beat valid; registered
m_tlast  out  1  source end of packet
m_tuser_vendor  out  USER_W  source sideband
m_tdata  out  DATA_W  source payload
m_tkeep  out  DATA_W/8  source byte enables
m_tready  in  1  source ready
count  out  $clog2(DEPTH)+1  beats held (RAM + output register)
pkt_cnt  out  $clog2(DEPTH)+1  complete packets held (tlast beats stored, not yet popped)
almost_full  out  1  count >= AFULL_TH; registered
saf_ovf  out  1  sticky; see Optional Feature; 0 when feature is compiled out

Behaviour:
- Reset (rst_n=0 at posedge clk) clears all state:
  - s_tready=0, m_tvalid=0, count=0, pkt_cnt=0, almost_full=0, saf_ovf=0.
  - m_tdata, m_tkeep, m_tlast, m_tuser_vendor are driven to 0.
  - s_tready rises on the first posedge with rst_n=1.
- Reset mid-packet discards all stored beats. No partial packet is emitted after reset.
- Push: s_tvalid & s_tready. Pop: m_tvalid & m_tready. count(next) = count + push - pop.
- s_tready(next) = (count(next) < DEPTH). No combinational path from m_tready to s_tready.
  - When full, a pop frees a slot, but s_tready stays low in that cycle and rises the next cycle.
- Latency: a beat pushed at edge N into an empty FIFO appears on m_tvalid after edge N+1 (1 cycle).
- Full throughput: 1 beat/cycle sustained with m_tready=1 and DEPTH>=4.
- m_tvalid, once high, stays high with all payload fields stable until popped (AXI-S rule).
- Ordering: strict FIFO. Beats are never reordered, dropped or duplicated.
- pkt_cnt(next) = pkt_cnt + (push & s_tlast) - (pop & m_tlast).
- Simultaneous push and pop at any occupancy (including count=1) leaves count unchanged and keeps data ordered.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. The full/empty decision comes from count, not pointer equality.
- s_tvalid with s_tready=0 has no effect. Payload inputs are ignored when s_tvalid=0.
- almost_full is updated from count(next).

Optional Feature:
PCIE_SS_AXIS_PKT_FIFO_SAF_EN
- Defined: store-and-forward mode.
  - The first beat of a packet is presented on m_tvalid only when pkt_cnt>0 (its tlast beat is stored).
  - Once a packet starts, all of its beats are released as available.
  - Deadlock escape: if count==DEPTH and pkt_cnt==0, output switches to cut-through for the current packet and saf_ovf sets (sticky until reset).
- Undefined: cut-through. Beats are released as soon as stored, and saf_ovf is tied 0.

Test Plan:
- Reset then single beat (tdata=0xA5.., tkeep all-ones, tlast=1), m_tready=1 -> m_tvalid high 1 cycle after push; identical payload; pkt_cnt 0->1->0.
- Burst of 16 beats with m_tready=0, DEPTH=16 -> s_tready drops after the 16th push; count=16; almost_full set at count 12. Then m_tready=1 -> 16 beats out in order; s_tready returns the cycle after the first pop.
- Full-rate streaming of 100 beats, packets of 3 beats, random m_tready -> no loss or reorder; m_tvalid never drops while m_tready=0; pkt_cnt matches scoreboard every cycle.
- Simultaneous push and pop at count=1 and at count=DEPTH-1 -> count unchanged; data order preserved across pointer wrap.
- rst_n=0 for 1 cycle mid-packet with count=7 -> next edge: count=0, pkt_cnt=0, m_tvalid=0; first beat after reset is the new packet's first beat.
- With SAF_EN: 4-beat packet, tlast late -> m_tvalid stays 0 until tlast is stored. 20-beat packet, DEPTH=16 -> cut-through fallback, saf_ovf=1, all 20 beats delivered in order.
